// File: rtl/scale_tile_fifo.sv
// Assembles LANES_NUM-wide FP32 scale beats into ELEMS-element tiles and queues
// up to DEPTH complete tiles in a show-ahead FIFO for the dequant scale sequencer.
module scale_tile_fifo #(
   parameter int LANES_NUM = 16,
   parameter int FP_MANT_W = 23,
   parameter int FP_EXP_W  = 8,
   parameter int ELEMS     = 256,
   parameter int DEPTH     = 2
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   flush_i,
   input  logic                                   in_valid_i,
   output logic                                   in_ready_o,
   input  logic [LANES_NUM*FP_MANT_W-1:0]         in_mant_i,
   input  logic [LANES_NUM*FP_EXP_W-1:0]          in_exp_i,
   input  logic                                   pop_i,
   output logic                                   empty_o,
   output logic                                   full_o,
   output logic [$clog2(DEPTH+1)-1:0]             count_o,
   output logic [$clog2(ELEMS/LANES_NUM)-1:0]     beat_cnt_o,
   output logic [FP_MANT_W*ELEMS-1:0]             tile_mant_o,
   output logic [FP_EXP_W*ELEMS-1:0]              tile_exp_o,
   output logic                                   err_pop_empty_o
);

   localparam int BEATS   = ELEMS / LANES_NUM;
   localparam int BEAT_MW = LANES_NUM * FP_MANT_W;
   localparam int BEAT_EW = LANES_NUM * FP_EXP_W;
   localparam int TILE_MW = ELEMS * FP_MANT_W;
   localparam int TILE_EW = ELEMS * FP_EXP_W;
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int BCNT_W  = $clog2(BEATS);
   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [BCNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic               err_q, err_d;
   logic [TILE_MW-1:0] asm_mant_q, asm_mant_d;
   logic [TILE_EW-1:0] asm_exp_q, asm_exp_d;
   logic [TILE_MW-1:0] mem_mant_q [DEPTH];
   logic [TILE_MW-1:0] mem_mant_d [DEPTH];
   logic [TILE_EW-1:0] mem_exp_q  [DEPTH];
   logic [TILE_EW-1:0] mem_exp_d  [DEPTH];

   logic last_beat;
   logic accept;
   logic commit;
   logic pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // A flush discards the beat and pop offered in the same cycle, but ready is
   // still reported from the current occupancy.
   always_comb begin
      last_beat  = (beat_cnt_q == BCNT_W'(BEATS - 1));
      in_ready_o = !last_beat || (count_q < CNT_W'(DEPTH)) || pop_i;
      accept     = in_valid_i && in_ready_o && !flush_i;
      commit     = accept && last_beat;
      pop_ok     = pop_i && (count_q != '0) && !flush_i;
   end

   always_comb begin
      asm_mant_d = asm_mant_q;
      asm_exp_d  = asm_exp_q;
      for (int b = 0; b < BEATS; b++) begin
         if (accept && (beat_cnt_q == BCNT_W'(b))) begin
            asm_mant_d[b*BEAT_MW +: BEAT_MW] = in_mant_i;
            asm_exp_d[b*BEAT_EW +: BEAT_EW]  = in_exp_i;
         end
      end
   end

   // The committed tile is the assembly register merged with the final beat,
   // so it lands in the slot on the same edge the last beat is accepted.
   always_comb begin
      mem_mant_d = mem_mant_q;
      mem_exp_d  = mem_exp_q;
      if (commit) begin
         mem_mant_d[wr_ptr_q] = asm_mant_d;
         mem_exp_d[wr_ptr_q]  = asm_exp_d;
      end
   end

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      err_d      = err_q;
      if (flush_i) begin
         beat_cnt_d = '0;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (accept) begin
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + BCNT_W'(1);
         end
         if (commit) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         if (commit && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop_ok && !commit) begin
            count_d = count_q - CNT_W'(1);
         end
         if (pop_i && (count_q == '0)) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_q <= '0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         err_q      <= err_d;
      end
   end

   // Tile storage is only ever read through a valid slot, so it carries no reset.
   always_ff @(posedge clk) begin
      asm_mant_q <= asm_mant_d;
      asm_exp_q  <= asm_exp_d;
      mem_mant_q <= mem_mant_d;
      mem_exp_q  <= mem_exp_d;
   end

   always_comb begin
      empty_o         = (count_q == '0);
      full_o          = (count_q == CNT_W'(DEPTH));
      count_o         = count_q;
      beat_cnt_o      = beat_cnt_q;
      err_pop_empty_o = err_q;
      tile_mant_o     = empty_o ? '0 : mem_mant_q[rd_ptr_q];
      tile_exp_o      = empty_o ? '0 : mem_exp_q[rd_ptr_q];
   end

endmodule

// File: tb/tb_scale_tile_fifo.sv
// Self-checking bench for scale_tile_fifo: directed scenarios plus randomized
// traffic checked against a queue-of-tiles reference model.
module tb_scale_tile_fifo;

   localparam int LANES = 16;
   localparam int MW    = 23;
   localparam int EW    = 8;
   localparam int ELEMS = 256;
   localparam int DEPTH = 2;
   localparam int BEATS = ELEMS / LANES;
   localparam int BMW   = LANES * MW;
   localparam int BEW   = LANES * EW;
   localparam int TMW   = ELEMS * MW;
   localparam int TEW   = ELEMS * EW;

   logic           clk;
   logic           rst;
   logic           flush_i;
   logic           in_valid_i;
   logic           in_ready_o;
   logic [BMW-1:0] in_mant_i;
   logic [BEW-1:0] in_exp_i;
   logic           pop_i;
   logic           empty_o;
   logic           full_o;
   logic [1:0]     count_o;
   logic [3:0]     beat_cnt_o;
   logic [TMW-1:0] tile_mant_o;
   logic [TEW-1:0] tile_exp_o;
   logic           err_pop_empty_o;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: stored tiles as a queue, partial tile filled element-wise.
   logic [TMW-1:0] q_mant [$];
   logic [TEW-1:0] q_exp  [$];
   logic [TMW-1:0] part_mant;
   logic [TEW-1:0] part_exp;
   int             m_beat;
   logic           m_err;

   logic rdy_seen;
   logic rdy_exp;
   int   d;

   scale_tile_fifo #(
      .LANES_NUM(LANES), .FP_MANT_W(MW), .FP_EXP_W(EW), .ELEMS(ELEMS), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_mant_i(in_mant_i), .in_exp_i(in_exp_i),
      .pop_i(pop_i), .empty_o(empty_o), .full_o(full_o),
      .count_o(count_o), .beat_cnt_o(beat_cnt_o),
      .tile_mant_o(tile_mant_o), .tile_exp_o(tile_exp_o),
      .err_pop_empty_o(err_pop_empty_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [BMW-1:0] pat_mant(input int t, input int k);
      logic [BMW-1:0] m;
      for (int l = 0; l < LANES; l++) m[l*MW +: MW] = MW'((t << 12) + LANES * k + l);
      return m;
   endfunction

   function automatic logic [BEW-1:0] pat_exp(input int t, input int k);
      logic [BEW-1:0] e;
      for (int l = 0; l < LANES; l++) e[l*EW +: EW] = EW'(t * 16 + k);
      return e;
   endfunction

   function automatic logic [TMW-1:0] tile_mant_of(input int t);
      logic [TMW-1:0] m;
      for (int i = 0; i < ELEMS; i++) m[i*MW +: MW] = MW'((t << 12) + i);
      return m;
   endfunction

   function automatic logic [TEW-1:0] tile_exp_of(input int t);
      logic [TEW-1:0] e;
      for (int i = 0; i < ELEMS; i++) e[i*EW +: EW] = EW'(t * 16 + i / 16);
      return e;
   endfunction

   function automatic logic [BMW-1:0] rand_mant();
      logic [BMW-1:0] m;
      for (int l = 0; l < LANES; l++) m[l*MW +: MW] = MW'($urandom);
      return m;
   endfunction

   function automatic logic [BEW-1:0] rand_exp();
      logic [BEW-1:0] e;
      for (int l = 0; l < LANES; l++) e[l*EW +: EW] = EW'($urandom);
      return e;
   endfunction

   function automatic int diff_mant(input logic [TMW-1:0] a, input logic [TMW-1:0] b);
      for (int i = 0; i < ELEMS; i++) if (a[i*MW +: MW] !== b[i*MW +: MW]) return i;
      return -1;
   endfunction

   function automatic int diff_exp(input logic [TEW-1:0] a, input logic [TEW-1:0] b);
      for (int i = 0; i < ELEMS; i++) if (a[i*EW +: EW] !== b[i*EW +: EW]) return i;
      return -1;
   endfunction

   function automatic logic [TMW-1:0] head_mant();
      return (q_mant.size() > 0) ? q_mant[0] : '0;
   endfunction

   function automatic logic [TEW-1:0] head_exp();
      return (q_exp.size() > 0) ? q_exp[0] : '0;
   endfunction

   task automatic model_step(input logic r, input logic f, input logic v, input logic p,
                             input logic [BMW-1:0] m, input logic [BEW-1:0] e);
      logic rdy;
      if (r) begin
         q_mant.delete(); q_exp.delete(); m_beat = 0; m_err = 1'b0;
      end else if (f) begin
         q_mant.delete(); q_exp.delete(); m_beat = 0;
      end else begin
         rdy = (m_beat != BEATS - 1) || (q_mant.size() < DEPTH) || p;
         if (p && q_mant.size() == 0) m_err = 1'b1;
         if (p && q_mant.size() > 0) begin
            void'(q_mant.pop_front()); void'(q_exp.pop_front());
         end
         if (v && rdy) begin
            for (int l = 0; l < LANES; l++) begin
               part_mant[(m_beat*LANES + l)*MW +: MW] = m[l*MW +: MW];
               part_exp[(m_beat*LANES + l)*EW +: EW]  = e[l*EW +: EW];
            end
            if (m_beat == BEATS - 1) begin
               q_mant.push_back(part_mant); q_exp.push_back(part_exp); m_beat = 0;
            end else begin
               m_beat++;
            end
         end
      end
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic drive_cycle(input logic r, input logic f, input logic v, input logic p,
                              input logic [BMW-1:0] m, input logic [BEW-1:0] e);
      rst = r; flush_i = f; in_valid_i = v; pop_i = p; in_mant_i = m; in_exp_i = e;
      #1;
      rdy_seen = in_ready_o;
      rdy_exp  = (m_beat != BEATS - 1) || (q_mant.size() < DEPTH) || p;
      @(posedge clk);
      model_step(r, f, v, p, m, e);
      @(negedge clk);
      rst = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; pop_i = 1'b0;
   endtask

   task automatic send_pat_tile(input int t);
      for (int k = 0; k < BEATS; k++) drive_cycle(0, 0, 1, 0, pat_mant(t, k), pat_exp(t, k));
   endtask

   task automatic test_reset();
      drive_cycle(1, 0, 0, 0, '0, '0);
      #1;
      n_checks++; if (empty_o !== 1'b1) $display("[TB] FAIL reset_empty: got %b want 1", empty_o); else n_pass++;
      n_checks++; if (full_o !== 1'b0) $display("[TB] FAIL reset_full: got %b want 0", full_o); else n_pass++;
      n_checks++; if (in_ready_o !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", in_ready_o); else n_pass++;
      n_checks++; if (count_o !== 2'd0) $display("[TB] FAIL reset_count: got %0d want 0", count_o); else n_pass++;
      n_checks++; if (beat_cnt_o !== 4'd0) $display("[TB] FAIL reset_beat: got %0d want 0", beat_cnt_o); else n_pass++;
      n_checks++; if (err_pop_empty_o !== 1'b0) $display("[TB] FAIL reset_err: got %b want 0", err_pop_empty_o); else n_pass++;
      n_checks++; if (tile_mant_o !== '0 || tile_exp_o !== '0) $display("[TB] FAIL reset_tile_zero: got nonzero want 0"); else n_pass++;
   endtask

   task automatic test_single_tile();
      for (int k = 0; k < BEATS; k++) begin
         drive_cycle(0, 0, 1, 0, pat_mant(0, k), pat_exp(0, k));
         n_checks++; if (rdy_seen !== 1'b1) $display("[TB] FAIL single_ready beat %0d: got %b want 1", k, rdy_seen); else n_pass++;
         if (k == BEATS - 2) begin
            n_checks++; if (empty_o !== 1'b1) $display("[TB] FAIL single_empty_before: got %b want 1", empty_o); else n_pass++;
         end
      end
      n_checks++; if (empty_o !== 1'b0) $display("[TB] FAIL single_empty_after: got %b want 0", empty_o); else n_pass++;
      n_checks++; if (count_o !== 2'd1) $display("[TB] FAIL single_count: got %0d want 1", count_o); else n_pass++;
      d = diff_mant(tile_mant_o, tile_mant_of(0));
      n_checks++; if (d >= 0) $display("[TB] FAIL single_mant elem %0d: got %h want %h", d, tile_mant_o[d*MW +: MW], d); else n_pass++;
      d = diff_exp(tile_exp_o, tile_exp_of(0));
      n_checks++; if (d >= 0) $display("[TB] FAIL single_exp elem %0d: got %h want %h", d, tile_exp_o[d*EW +: EW], d / 16); else n_pass++;
      drive_cycle(0, 0, 0, 1, '0, '0);
      n_checks++; if (empty_o !== 1'b1) $display("[TB] FAIL single_pop_empty: got %b want 1", empty_o); else n_pass++;
   endtask

   task automatic test_backpressure();
      send_pat_tile(0);
      send_pat_tile(1);
      n_checks++; if (full_o !== 1'b1) $display("[TB] FAIL bp_full: got %b want 1", full_o); else n_pass++;
      for (int k = 0; k < BEATS - 1; k++) begin
         drive_cycle(0, 0, 1, 0, pat_mant(2, k), pat_exp(2, k));
         n_checks++; if (rdy_seen !== 1'b1) $display("[TB] FAIL bp_ready beat %0d: got %b want 1", k, rdy_seen); else n_pass++;
      end
      n_checks++; if (beat_cnt_o !== 4'd15) $display("[TB] FAIL bp_beat_cnt: got %0d want 15", beat_cnt_o); else n_pass++;
      drive_cycle(0, 0, 1, 0, pat_mant(2, BEATS - 1), pat_exp(2, BEATS - 1));
      n_checks++; if (rdy_seen !== 1'b0) $display("[TB] FAIL bp_stall: got %b want 0", rdy_seen); else n_pass++;
      n_checks++; if (count_o !== 2'd2 || beat_cnt_o !== 4'd15) $display("[TB] FAIL bp_stall_state: got count %0d beat %0d want 2 15", count_o, beat_cnt_o); else n_pass++;
      drive_cycle(0, 0, 1, 1, pat_mant(2, BEATS - 1), pat_exp(2, BEATS - 1));
      n_checks++; if (rdy_seen !== 1'b1) $display("[TB] FAIL bp_pop_ready: got %b want 1", rdy_seen); else n_pass++;
      n_checks++; if (count_o !== 2'd2) $display("[TB] FAIL bp_pop_count: got %0d want 2", count_o); else n_pass++;
      d = diff_mant(tile_mant_o, tile_mant_of(1));
      n_checks++; if (d >= 0) $display("[TB] FAIL bp_head1 elem %0d: got %h want %h", d, tile_mant_o[d*MW +: MW], (1 << 12) + d); else n_pass++;
      drive_cycle(0, 0, 0, 1, '0, '0);
      d = diff_exp(tile_exp_o, tile_exp_of(2));
      n_checks++; if (d >= 0) $display("[TB] FAIL bp_head2 elem %0d: got %h want %h", d, tile_exp_o[d*EW +: EW], 32 + d / 16); else n_pass++;
      drive_cycle(0, 0, 0, 1, '0, '0);
      n_checks++; if (empty_o !== 1'b1) $display("[TB] FAIL bp_drained: got %b want 1", empty_o); else n_pass++;
   endtask

   task automatic test_ordering();
      send_pat_tile(3);
      send_pat_tile(4);
      d = diff_mant(tile_mant_o, tile_mant_of(3));
      n_checks++; if (d >= 0) $display("[TB] FAIL order_head0 elem %0d: got %h want %h", d, tile_mant_o[d*MW +: MW], (3 << 12) + d); else n_pass++;
      drive_cycle(0, 0, 0, 1, '0, '0);
      d = diff_mant(tile_mant_o, tile_mant_of(4));
      n_checks++; if (d >= 0) $display("[TB] FAIL order_head1 elem %0d: got %h want %h", d, tile_mant_o[d*MW +: MW], (4 << 12) + d); else n_pass++;
      d = diff_exp(tile_exp_o, tile_exp_of(4));
      n_checks++; if (d >= 0) $display("[TB] FAIL order_head1_exp elem %0d: got %h want %h", d, tile_exp_o[d*EW +: EW], 64 + d / 16); else n_pass++;
      drive_cycle(0, 0, 0, 1, '0, '0);
      n_checks++; if (empty_o !== 1'b1) $display("[TB] FAIL order_empty: got %b want 1", empty_o); else n_pass++;
      n_checks++; if (tile_mant_o !== '0 || tile_exp_o !== '0) $display("[TB] FAIL order_zero_out: got nonzero want 0"); else n_pass++;
   endtask

   task automatic test_pop_empty();
      drive_cycle(1, 0, 0, 0, '0, '0);
      drive_cycle(0, 0, 0, 1, '0, '0);
      n_checks++; if (count_o !== 2'd0) $display("[TB] FAIL popempty_count: got %0d want 0", count_o); else n_pass++;
      n_checks++; if (err_pop_empty_o !== 1'b1) $display("[TB] FAIL popempty_err: got %b want 1", err_pop_empty_o); else n_pass++;
      for (int k = 0; k < BEATS; k++) drive_cycle(0, 0, 1, 0, rand_mant(), rand_exp());
      n_checks++; if (err_pop_empty_o !== 1'b1) $display("[TB] FAIL popempty_sticky: got %b want 1", err_pop_empty_o); else n_pass++;
      n_checks++; if (count_o !== 2'd1) $display("[TB] FAIL popempty_commit: got %0d want 1", count_o); else n_pass++;
   endtask

   task automatic test_flush();
      for (int k = 0; k < 5; k++) drive_cycle(0, 0, 1, 0, rand_mant(), rand_exp());
      n_checks++; if (beat_cnt_o !== 4'd5) $display("[TB] FAIL flush_pre_beat: got %0d want 5", beat_cnt_o); else n_pass++;
      drive_cycle(0, 1, 1, 1, rand_mant(), rand_exp());
      n_checks++; if (rdy_seen !== 1'b1) $display("[TB] FAIL flush_ready: got %b want 1", rdy_seen); else n_pass++;
      n_checks++; if (count_o !== 2'd0 || beat_cnt_o !== 4'd0) $display("[TB] FAIL flush_clear: got count %0d beat %0d want 0 0", count_o, beat_cnt_o); else n_pass++;
      n_checks++; if (err_pop_empty_o !== 1'b1) $display("[TB] FAIL flush_err_kept: got %b want 1", err_pop_empty_o); else n_pass++;
      send_pat_tile(5);
      n_checks++; if (count_o !== 2'd1) $display("[TB] FAIL flush_refill_count: got %0d want 1", count_o); else n_pass++;
      d = diff_mant(tile_mant_o, tile_mant_of(5));
      n_checks++; if (d >= 0) $display("[TB] FAIL flush_refill elem %0d: got %h want %h", d, tile_mant_o[d*MW +: MW], (5 << 12) + d); else n_pass++;
   endtask

   task automatic test_reset_mid();
      send_pat_tile(6);
      for (int k = 0; k < 9; k++) drive_cycle(0, 0, 1, 0, rand_mant(), rand_exp());
      n_checks++; if (beat_cnt_o !== 4'd9 || count_o !== 2'd2) $display("[TB] FAIL rstmid_pre: got beat %0d count %0d want 9 2", beat_cnt_o, count_o); else n_pass++;
      drive_cycle(1, 0, 1, 0, rand_mant(), rand_exp());
      #1;
      n_checks++; if (empty_o !== 1'b1 || full_o !== 1'b0) $display("[TB] FAIL rstmid_flags: got empty %b full %b want 1 0", empty_o, full_o); else n_pass++;
      n_checks++; if (in_ready_o !== 1'b1) $display("[TB] FAIL rstmid_ready: got %b want 1", in_ready_o); else n_pass++;
      n_checks++; if (err_pop_empty_o !== 1'b0) $display("[TB] FAIL rstmid_err: got %b want 0", err_pop_empty_o); else n_pass++;
      n_checks++; if (beat_cnt_o !== 4'd0) $display("[TB] FAIL rstmid_beat: got %0d want 0", beat_cnt_o); else n_pass++;
   endtask

   task automatic test_random();
      logic v, p, f;
      for (int c = 0; c < 600; c++) begin
         v = ($urandom % 4) != 0;
         p = ($urandom % 16) < 3;
         f = ($urandom % 80) == 0;
         drive_cycle(0, f, v, p, rand_mant(), rand_exp());
         n_checks++; if (rdy_seen !== rdy_exp) $display("[TB] FAIL rand_ready cyc %0d: got %b want %b", c, rdy_seen, rdy_exp); else n_pass++;
         n_checks++; if (count_o !== 2'(q_mant.size()) || beat_cnt_o !== 4'(m_beat)) $display("[TB] FAIL rand_counts cyc %0d: got %0d/%0d want %0d/%0d", c, count_o, beat_cnt_o, q_mant.size(), m_beat); else n_pass++;
         n_checks++; if (empty_o !== (q_mant.size() == 0) || full_o !== (q_mant.size() == DEPTH) || err_pop_empty_o !== m_err) $display("[TB] FAIL rand_flags cyc %0d: got e%b f%b err%b want e%b f%b err%b", c, empty_o, full_o, err_pop_empty_o, q_mant.size() == 0, q_mant.size() == DEPTH, m_err); else n_pass++;
         d = diff_mant(tile_mant_o, head_mant());
         n_checks++; if (d >= 0) $display("[TB] FAIL rand_mant cyc %0d elem %0d: got %h want %h", c, d, tile_mant_o[d*MW +: MW], head_mant() >> (d*MW)); else n_pass++;
         d = diff_exp(tile_exp_o, head_exp());
         n_checks++; if (d >= 0) $display("[TB] FAIL rand_exp cyc %0d elem %0d: got %h want %h", c, d, tile_exp_o[d*EW +: EW], head_exp() >> (d*EW)); else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; pop_i = 1'b0;
      in_mant_i = '0; in_exp_i = '0;
      part_mant = '0; part_exp = '0; m_beat = 0; m_err = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_tile();
      test_backpressure();
      test_ordering();
      test_pop_empty();
      test_flush();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
